// File: rtl/graph_assembly_deser.sv
// Serial-to-parallel front stage: frames LSB-first bits into WIDTH-bit words,
// buffers them in a DEPTH-entry FIFO and counts framing errors (saturating).
module graph_assembly_deser #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             a_valid,
    input  logic             a_first,
    output logic             a_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [ERR_W-1:0] err_cnt,
    output logic             dbg_state
);
    // Handshakes: a bit transfers on a rising edge where a_valid && a_ready;
    // a word leaves the FIFO on a rising edge where dout_valid && dout_ready.

    localparam int CNT_W = $clog2(WIDTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   w_bit_cnt_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [WIDTH-1:0]   w_word;
    logic               w_push;
    logic               w_pop;
    logic               w_accept;
    logic               w_err_inc;
    logic               w_last_bit;
    logic               w_full;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [OCC_W-1:0]   r_count;
    logic [ERR_W-1:0]   r_err_cnt;

    assign w_full     = (r_count == OCC_W'(DEPTH));
    assign w_last_bit = (r_bit_cnt == CNT_W'(WIDTH - 1));
    // Only a completing bit needs FIFO space, so only that case back-pressures.
    assign a_ready    = !((r_state == COLLECT) && w_last_bit && w_full);
    assign w_accept   = a_valid && a_ready;
    assign w_word     = r_shift | (WIDTH'(a) << r_bit_cnt);

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_push        = 1'b0;
        w_err_inc     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (a_first) begin
                        w_shift_nxt   = {{(WIDTH-1){1'b0}}, a};
                        w_bit_cnt_nxt = CNT_W'(1);
                        w_state_nxt   = COLLECT;
                    end else begin
                        w_err_inc = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (w_accept) begin
                    if (a_first) begin
                        w_err_inc     = 1'b1;
                        w_shift_nxt   = {{(WIDTH-1){1'b0}}, a};
                        w_bit_cnt_nxt = CNT_W'(1);
                    end else if (w_last_bit) begin
                        w_push        = 1'b1;
                        w_shift_nxt   = '0;
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = IDLE;
                    end else begin
                        w_shift_nxt   = w_word;
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    assign w_pop = (r_count != '0) && dout_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + OCC_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_err_inc && (r_err_cnt != {ERR_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    assign dout_valid = (r_count != '0);
    assign dout       = dout_valid ? r_mem[r_rd_ptr] : '0;
    assign err_cnt    = r_err_cnt;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_graph_assembly_deser.sv
// Bench for graph_assembly_deser: drives framed serial words and checks the
// emitted words against an expected queue, plus flow control and error counts.
module tb_graph_assembly_deser;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst;
    logic             a;
    logic             a_valid;
    logic             a_first;
    logic             a_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [7:0]       err_cnt;
    logic             dbg_state;

    logic             a_ready2;
    logic [WIDTH-1:0] dout2;
    logic             dout_valid2;
    logic [1:0]       err_cnt2;
    logic             dbg_state2;

    int               n_checks;
    int               n_errors;
    int               stall_cnt;
    logic [WIDTH-1:0] exp_q[$];

    graph_assembly_deser #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .a_first(a_first),
        .a_ready(a_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    graph_assembly_deser #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .a_first(a_first),
        .a_ready(a_ready2), .dout(dout2), .dout_valid(dout_valid2),
        .dout_ready(dout_ready), .err_cnt(err_cnt2), .dbg_state(dbg_state2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // scoreboard: every word the DUT hands downstream must be the next expected one
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            chk("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("dout", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
    end

    // drivers: entered and left at posedge+1
    task automatic send_bit(input logic b, input logic first);
        int waited;
        a       = b;
        a_first = first;
        a_valid = 1'b1;
        waited  = 0;
        forever begin
            @(negedge clk);
            if (a_ready) break;
            stall_cnt++;
            waited++;
            if (waited > 200) begin
                chk("accept_timeout", 32'(waited), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_first = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) begin
            send_bit(w[i], i == 0);
        end
        exp_q.push_back(w);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || dout_valid) && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
        chk("drain_valid", 32'(dout_valid), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        stall_cnt  = 0;
        rst        = 1'b1;
        a          = 1'b0;
        a_valid    = 1'b0;
        a_first    = 1'b0;
        dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd1);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: single word 1101, visible the cycle after its last bit
        dout_ready = 1'b1;
        send_word(4'b1101);
        @(negedge clk);
        chk("t1_valid", 32'(dout_valid), 32'd1);
        chk("t1_dout", 32'(dout), 32'hD);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t1_valid_gone", 32'(dout_valid), 32'd0);
        chk("t1_err", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;

        // 2: back-pressure with a full FIFO and a pending last bit
        dout_ready = 1'b0;
        send_word(4'h3);
        send_word(4'hA);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        a       = 1'b0;
        a_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("t2_a_ready_low", 32'(a_ready), 32'd0);
            chk("t2_head", 32'(dout), 32'h3);
            chk("t2_state", 32'(dbg_state), 32'd1);
        end
        @(posedge clk);
        #1;
        fork
            send_bit(1'b0, 1'b0);
            begin
                idle_cycles(2);
                dout_ready = 1'b1;
            end
        join
        exp_q.push_back(4'h5);
        wait_drain();

        // 3: restart mid-word discards the partial word
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_word(4'h6);
        @(negedge clk);
        chk("t3_err", 32'(err_cnt), 32'd1);
        @(posedge clk);
        #1;
        wait_drain();

        // 4: orphan bits in IDLE, and saturation of a 2-bit counter
        do_reset();
        for (int n = 1; n <= 6; n++) begin
            send_bit(n[0], 1'b0);
            @(negedge clk);
            chk("t4_err", 32'(err_cnt), 32'(n));
            chk("t4_err_sat", 32'(err_cnt2), 32'((n > 3) ? 3 : n));
            chk("t4_no_valid", 32'(dout_valid), 32'd0);
            @(posedge clk);
            #1;
        end

        // 5: asynchronous reset with a buffered word and a partial one
        dout_ready = 1'b0;
        for (int i = 0; i < WIDTH; i++) send_bit(1'(4'hC >> i), i == 0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        @(negedge clk);
        chk("t5_pre_valid", 32'(dout_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_dout", 32'(dout), 32'd0);
        chk("t5_async_valid", 32'(dout_valid), 32'd0);
        chk("t5_async_err", 32'(err_cnt), 32'd0);
        chk("t5_async_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        dout_ready = 1'b1;
        send_word(4'h9);
        wait_drain();

        // 6: continuous streaming through FIFO wrap
        stall_cnt = 0;
        for (int v = 0; v < 10; v++) send_word(4'(v));
        chk("t6_stalls", 32'(stall_cnt), 32'd0);
        wait_drain();
        chk("t6_err", 32'(err_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/graph_assembly_deser.md
Name: graph_assembly_deser

Overview:
- Serial-to-parallel front stage that assembles WIDTH-bit words from a single-bit stream and feeds them, buffered, into the parallel `din` of the downstream WIDTH-parameterised word consumer.
- Adds framing (start-of-word marker), a DEPTH-entry output FIFO with valid/ready handshake, and a saturating framing-error counter.
- Sits directly upstream of the parallel consumer in the instance-assembly design: its `dout` connects to the consumer's `din`.

Parameters:
- WIDTH, 4, word width in bits; legal range WIDTH >= 2.
- DEPTH, 2, output FIFO entries; legal range DEPTH >= 1.
- ERR_W, 8, width of the framing-error counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  1  serial data bit.
- a_valid  input  1  `a` / `a_first` valid this cycle.
- a_first  input  1  marks the bit as bit 0 (LSB) of a new word.
- a_ready  output  1  stage accepts a bit this cycle.
- dout  output  WIDTH  head-of-FIFO word; drives the downstream `din`.
- dout_valid  output  1  FIFO non-empty.
- dout_ready  input  1  downstream consumes the head word.
- err_cnt  output  ERR_W  saturating framing-error count.

Behaviour:
- Reset (async assert, any cycle):
  - FSM to IDLE, bit_cnt=0, shift reg=0, FIFO emptied.
  - dout=0, dout_valid=0, err_cnt=0.
  - a_ready=1 in IDLE after reset.
  - A partially assembled word is lost with no error count.
- Bit accept: a bit is accepted only when `a_valid && a_ready`. Bits are LSB first.
- FSM:
  - IDLE:
    - Accepted bit with a_first=1: store as bit 0, bit_cnt=1, go to COLLECT.
    - Accepted bit with a_first=0: bit dropped, err_cnt+1, stay in IDLE.
  - COLLECT:
    - Accepted bit with a_first=0: store at position bit_cnt, bit_cnt+1.
    - When the stored bit is position WIDTH-1: word pushed into the FIFO on the same edge, bit_cnt=0, go to IDLE.
    - Accepted bit with a_first=1: partial word discarded, err_cnt+1; the bit becomes bit 0 of a new word (bit_cnt=1, stay in COLLECT).
- a_ready (combinational, no path from dout_ready):
  - 0 only when the FSM is in COLLECT, bit_cnt==WIDTH-1, and the FIFO holds DEPTH entries.
  - 1 otherwise.
  - Consequence: a completing bit is never accepted into a full FIFO, and same-cycle push-on-full never occurs.
- Latency: the last bit is accepted at edge N; dout/dout_valid reflect the word after edge N (visible in cycle N+1) when the FIFO was empty.
- FIFO:
  - Circular, with read/write pointers wrapping at DEPTH and an occupancy count 0..DEPTH.
  - Pop on `dout_valid && dout_ready`.
  - Simultaneous push and pop: occupancy unchanged; head advances.
  - dout_ready while empty: ignored.
  - dout holds the head word while dout_valid=1 and not popped.
  - dout is 0 when empty.
- err_cnt saturates at 2^ERR_W-1 and never wraps.
- No dedicated abort input; only rst clears state.

Test Plan:
1. Reset, then send bits 1,0,1,1 (a_first on the first), dout_ready=1 → dout_valid=1 for one cycle with dout=4'b1101, one cycle after the 4th bit; err_cnt=0.
2. dout_ready=0, send three words 4'h3, 4'hA, then the first 3 bits of 4'h5 → after 2 words a_ready drops to 0 with bit_cnt=3. Raise dout_ready → 4'h3 pops, a_ready=1, the 4th bit is accepted, then dout order is 4'hA, 4'h5.
3. Send two bits, then a bit with a_first=1 followed by 3 more bits forming 4'h6 → err_cnt=1, only 4'h6 emitted.
4. In IDLE, send 5 bits with a_first=0 → all dropped, err_cnt=5, dout_valid stays 0. With ERR_W=2, send 6 bits → err_cnt saturates at 3.
5. Assert rst asynchronously mid-word with the FIFO holding 1 word → outputs go 0 immediately without a clock edge. After release, a fresh word 4'h9 is emitted correctly and the stale word never appears.
6. Continuous streaming with dout_ready=1 every cycle for 10 words (values 0..9), including FIFO wrap → all 10 emitted in order, with a_ready never deasserted.
